// File: rtl/uartb_core_if.sv
// Register-bus and serial-line bundle for uartb_core.
// master = CPU/line side driving the core; slave = the core itself.
interface uartb_core_if;
  logic [31:0] d;
  logic        wrtx;
  logic        wrbaud;
  logic        rd;
  logic        rxd;
  logic        txd;
  logic [7:0]  q;
  logic        dv;
  logic        ovr;
  logic        ferr;
  logic        busy;
  logic        mode;

  modport master (
    output d, wrtx, wrbaud, rd, rxd,
    input  txd, q, dv, ovr, ferr, busy, mode
  );

  modport slave (
    input  d, wrtx, wrbaud, rd, rxd,
    output txd, q, dv, ovr, ferr, busy, mode
  );
endinterface

// File: rtl/uartb_core.sv
// Full-duplex 8N1 UART with programmable divisor and a 4-byte transmit burst mode.
// One baud counter per direction; bit period is divisor+1 clocks.
module uartb_core #(
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned DIV_RST = 7
) (
  input logic         clk,
  input logic         rst,
  uartb_core_if.slave bus
);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

  logic [DIV_W-1:0] div_q, div_d;
  logic             mode_q, mode_d;

  tx_state_t        tx_st_q, tx_st_d;
  logic [31:0]      thr_q, thr_d;
  logic             thr_mode_q, thr_mode_d;
  logic             thr_full_q, thr_full_d;
  logic [31:0]      sh_q, sh_d;
  logic             burst_q, burst_d;
  logic [1:0]       byte_q, byte_d;
  logic [2:0]       bit_q, bit_d;
  logic [DIV_W-1:0] tcnt_q, tcnt_d;
  logic             txd_q, txd_d;
  logic             load;

  rx_state_t        rx_st_q, rx_st_d;
  logic             sync1_q, sync2_q, rx_prev_q;
  logic [DIV_W-1:0] rcnt_q, rcnt_d;
  logic [2:0]       rbit_q, rbit_d;
  logic [7:0]       rsr_q, rsr_d;
  logic [7:0]       q_q, q_d;
  logic             dv_q, dv_d, ovr_q, ovr_d, ferr_q, ferr_d;

  always_comb begin
    div_d      = div_q;
    mode_d     = mode_q;
    tx_st_d    = tx_st_q;
    thr_d      = thr_q;
    thr_mode_d = thr_mode_q;
    thr_full_d = thr_full_q;
    sh_d       = sh_q;
    burst_d    = burst_q;
    byte_d     = byte_q;
    bit_d      = bit_q;
    tcnt_d     = tcnt_q;
    txd_d      = txd_q;
    load       = 1'b0;

    if (bus.wrbaud) begin
      mode_d = bus.d[31];
      div_d  = bus.d[DIV_W-1:0];
    end

    // The shifter is consumed LSB first across all bytes, so after each
    // byte the next burst byte already sits in sh_q[7:0].
    case (tx_st_q)
      TX_IDLE: begin
        txd_d = 1'b1;
        if (thr_full_q) load = 1'b1;
      end
      TX_START: begin
        if (tcnt_q == '0) begin
          tcnt_d  = div_q;
          txd_d   = sh_q[0];
          sh_d    = sh_q >> 1;
          bit_d   = '0;
          tx_st_d = TX_DATA;
        end else begin
          tcnt_d = tcnt_q - DIV_W'(1);
        end
      end
      TX_DATA: begin
        if (tcnt_q == '0) begin
          tcnt_d = div_q;
          if (bit_q == 3'd7) begin
            txd_d   = 1'b1;
            tx_st_d = TX_STOP;
          end else begin
            txd_d = sh_q[0];
            sh_d  = sh_q >> 1;
            bit_d = bit_q + 3'd1;
          end
        end else begin
          tcnt_d = tcnt_q - DIV_W'(1);
        end
      end
      TX_STOP: begin
        if (tcnt_q == '0) begin
          if (burst_q && byte_q != 2'd3) begin
            byte_d  = byte_q + 2'd1;
            tcnt_d  = div_q;
            txd_d   = 1'b0;
            tx_st_d = TX_START;
          end else if (thr_full_q) begin
            load = 1'b1;
          end else begin
            txd_d   = 1'b1;
            tx_st_d = TX_IDLE;
          end
        end else begin
          tcnt_d = tcnt_q - DIV_W'(1);
        end
      end
      default: tx_st_d = TX_IDLE;
    endcase

    if (load) begin
      sh_d       = thr_q;
      burst_d    = thr_mode_q;
      byte_d     = '0;
      tcnt_d     = div_q;
      txd_d      = 1'b0;
      tx_st_d    = TX_START;
      thr_full_d = 1'b0;
    end

    // A write on the transfer edge refills the THR that was just emptied.
    if (bus.wrtx) begin
      thr_d      = bus.d;
      thr_mode_d = mode_q;
      thr_full_d = 1'b1;
    end
  end

  always_comb begin
    rx_st_d = rx_st_q;
    rcnt_d  = rcnt_q;
    rbit_d  = rbit_q;
    rsr_d   = rsr_q;
    q_d     = q_q;
    dv_d    = dv_q;
    ovr_d   = ovr_q;
    ferr_d  = ferr_q;

    if (bus.rd) begin
      dv_d  = 1'b0;
      ovr_d = 1'b0;
    end

    case (rx_st_q)
      RX_IDLE: begin
        if (rx_prev_q && !sync2_q) begin
          rcnt_d  = div_q >> 1;
          rx_st_d = RX_START;
        end
      end
      RX_START: begin
        if (rcnt_q == '0) begin
          if (sync2_q) begin
            rx_st_d = RX_IDLE;
          end else begin
            rcnt_d  = div_q;
            rbit_d  = '0;
            rx_st_d = RX_DATA;
          end
        end else begin
          rcnt_d = rcnt_q - DIV_W'(1);
        end
      end
      RX_DATA: begin
        if (rcnt_q == '0) begin
          rsr_d  = {sync2_q, rsr_q[7:1]};
          rcnt_d = div_q;
          if (rbit_q == 3'd7) rx_st_d = RX_STOP;
          else                rbit_d  = rbit_q + 3'd1;
        end else begin
          rcnt_d = rcnt_q - DIV_W'(1);
        end
      end
      RX_STOP: begin
        if (rcnt_q == '0) begin
          if (sync2_q) begin
            q_d    = rsr_q;
            dv_d   = 1'b1;
            ferr_d = 1'b0;
            ovr_d  = (ovr_q | dv_q) & ~bus.rd;
          end else begin
            ferr_d = 1'b1;
          end
          rx_st_d = RX_WAIT;
        end else begin
          rcnt_d = rcnt_q - DIV_W'(1);
        end
      end
      RX_WAIT: begin
        if (sync2_q) rx_st_d = RX_IDLE;
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q      <= DIV_W'(DIV_RST);
      mode_q     <= 1'b0;
      tx_st_q    <= TX_IDLE;
      thr_q      <= '0;
      thr_mode_q <= 1'b0;
      thr_full_q <= 1'b0;
      sh_q       <= '0;
      burst_q    <= 1'b0;
      byte_q     <= '0;
      bit_q      <= '0;
      tcnt_q     <= '0;
      txd_q      <= 1'b1;
      rx_st_q    <= RX_IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rcnt_q     <= '0;
      rbit_q     <= '0;
      rsr_q      <= '0;
      q_q        <= '0;
      dv_q       <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      div_q      <= div_d;
      mode_q     <= mode_d;
      tx_st_q    <= tx_st_d;
      thr_q      <= thr_d;
      thr_mode_q <= thr_mode_d;
      thr_full_q <= thr_full_d;
      sh_q       <= sh_d;
      burst_q    <= burst_d;
      byte_q     <= byte_d;
      bit_q      <= bit_d;
      tcnt_q     <= tcnt_d;
      txd_q      <= txd_d;
      rx_st_q    <= rx_st_d;
      sync1_q    <= bus.rxd;
      sync2_q    <= sync1_q;
      rx_prev_q  <= sync2_q;
      rcnt_q     <= rcnt_d;
      rbit_q     <= rbit_d;
      rsr_q      <= rsr_d;
      q_q        <= q_d;
      dv_q       <= dv_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
    end
  end

  assign bus.txd  = txd_q;
  assign bus.q    = q_q;
  assign bus.dv   = dv_q;
  assign bus.ovr  = ovr_q;
  assign bus.ferr = ferr_q;
  assign bus.busy = (tx_st_q != TX_IDLE) | thr_full_q;
  assign bus.mode = mode_q;

endmodule

// File: tb/tb_uartb_core.sv
// Scoreboard bench for uartb_core: a serial decoder on txd and a dv monitor
// each pop expected bytes pushed when TX words are issued.
module tb_uartb_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uartb_core_if ifc();

  logic [31:0] d_drv      = '0;
  logic        wrtx_drv   = 1'b0;
  logic        wrbaud_drv = 1'b0;
  logic        rd_dir     = 1'b0;
  logic        mon_rd     = 1'b0;
  logic        loop_en    = 1'b1;
  logic        rx_drv     = 1'b1;

  assign ifc.d      = d_drv;
  assign ifc.wrtx   = wrtx_drv;
  assign ifc.wrbaud = wrbaud_drv;
  assign ifc.rd     = rd_dir | mon_rd;
  assign ifc.rxd    = loop_en ? ifc.txd : rx_drv;

  uartb_core #(.DIV_W(16), .DIV_RST(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  typedef struct packed {
    logic [7:0] b;
    logic       contig;
  } txe_t;

  txe_t       txq[$];
  logic [7:0] rxq[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int bitp = 8;
  int last_start = -100000;
  bit rx_mon_en = 1'b0;
  bit cur_mode = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask

  task automatic skip(input int n, inout bit ab);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rst) begin
        ab = 1'b1;
        return;
      end
    end
  endtask

  // Independent 8N1 receiver on txd, sampling mid-bit by clock count.
  always begin : tx_decoder
    txe_t       e;
    logic [7:0] b;
    logic       s0, sstop;
    int         bp, st;
    bit         ab;
    @(negedge clk);
    if (!rst && ifc.txd === 1'b0) begin
      st = cyc;
      bp = bitp;
      ab = 1'b0;
      sstop = 1'b0;
      b = '0;
      skip(bp / 2, ab);
      s0 = ifc.txd;
      for (int i = 0; i < 8; i++) begin
        if (!ab) begin
          skip(bp, ab);
          b[i] = ifc.txd;
        end
      end
      if (!ab) begin
        skip(bp, ab);
        sstop = ifc.txd;
      end
      if (!ab) begin
        if (txq.size() == 0) begin
          bound_fail("tx_unexpected_byte");
        end else begin
          e = txq.pop_front();
          check("tx_start_bit", s0, 0);
          check("tx_byte", b, e.b);
          check("tx_stop_bit", sstop, 1);
          if (e.contig) check("tx_no_gap", st - last_start, 10 * bp);
        end
        last_start = st;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_rd) begin
      mon_rd = 1'b0;
    end else if (rx_mon_en && ifc.dv === 1'b1) begin
      if (rxq.size() == 0) bound_fail("rx_unexpected_byte");
      else check("rx_q", ifc.q, rxq.pop_front());
      check("rx_ovr", ifc.ovr, 0);
      mon_rd = 1'b1;
    end
  end

  task automatic set_baud(input bit m, input int div);
    @(negedge clk);
    d_drv = {m, 15'b0, 16'(div)};
    wrbaud_drv = 1'b1;
    @(negedge clk);
    wrbaud_drv = 1'b0;
    cur_mode = m;
    bitp = div + 1;
  endtask

  task automatic push_word(input logic [31:0] w, input bit burst, input bit contig);
    txe_t e;
    int n = burst ? 4 : 1;
    for (int i = 0; i < n; i++) begin
      e.b = w[8*i +: 8];
      e.contig = (i > 0) || contig;
      txq.push_back(e);
      if (rx_mon_en) rxq.push_back(e.b);
    end
  endtask

  task automatic write_tx(input logic [31:0] w, input bit contig);
    push_word(w, cur_mode, contig);
    @(negedge clk);
    d_drv = w;
    wrtx_drv = 1'b1;
    @(negedge clk);
    wrtx_drv = 1'b0;
  endtask

  task automatic wait_txd_low();
    int n = 0;
    while (ifc.txd !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) bound_fail("txd_start_wait");
  endtask

  task automatic wait_idle();
    int n = 0;
    while (ifc.busy !== 1'b0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) bound_fail("busy_wait");
    n = 0;
    while (rxq.size() > 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) bound_fail("rx_drain_wait");
    repeat (3 * bitp + 10) @(negedge clk);
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop);
    rx_drv = 1'b0;
    repeat (bitp) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (bitp) @(negedge clk);
    end
    rx_drv = stop;
    repeat (bitp) @(negedge clk);
    rx_drv = 1'b1;
    repeat (bitp) @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] w;
    int div;
    bit m;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_txd", ifc.txd, 1);
    check("rst_q", ifc.q, 0);
    check("rst_dv", ifc.dv, 0);
    check("rst_ovr", ifc.ovr, 0);
    check("rst_ferr", ifc.ferr, 0);
    check("rst_busy", ifc.busy, 0);
    check("rst_mode", ifc.mode, 0);

    set_baud(1'b0, 7);
    check("cfg_mode0", ifc.mode, 0);

    // Single byte with start-latency check
    rx_mon_en = 1'b1;
    push_word(32'h41, 1'b0, 1'b0);
    @(negedge clk);
    d_drv = 32'h41;
    wrtx_drv = 1'b1;
    @(negedge clk);
    wrtx_drv = 1'b0;
    check("txd_before_start", ifc.txd, 1);
    check("busy_thr_full", ifc.busy, 1);
    @(negedge clk);
    check("txd_start_1clk", ifc.txd, 0);
    wait_idle();
    check("busy_after_stop", ifc.busy, 0);

    // Overrun: two bytes unread, mode change during second frame
    rx_mon_en = 1'b0;
    write_tx(32'h41, 1'b0);
    wait_txd_low();
    write_tx(32'h42, 1'b1);
    repeat (100) @(negedge clk);
    set_baud(1'b1, 7);
    check("cfg_mode1", ifc.mode, 1);
    wait_idle();
    check("ovr_q", ifc.q, 32'h42);
    check("ovr_dv", ifc.dv, 1);
    check("ovr_set", ifc.ovr, 1);
    @(negedge clk);
    rd_dir = 1'b1;
    @(negedge clk);
    rd_dir = 1'b0;
    check("rd_clears_dv", ifc.dv, 0);
    check("rd_clears_ovr", ifc.ovr, 0);
    check("rd_keeps_q", ifc.q, 32'h42);

    // Burst word, then back to normal mode
    rx_mon_en = 1'b1;
    write_tx(32'h44434241, 1'b0);
    wait_idle();
    set_baud(1'b0, 7);
    write_tx(32'h0000005A, 1'b0);
    wait_idle();

    // RX glitch and framing error via directly driven line
    loop_en = 1'b0;
    rx_drv = 1'b1;
    repeat (4) @(negedge clk);
    rx_drv = 1'b0;
    repeat (2) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_dv", ifc.dv, 0);
    check("glitch_ferr", ifc.ferr, 0);
    drive_frame(8'h33, 1'b0);
    repeat (2 * bitp) @(negedge clk);
    check("ferr_set", ifc.ferr, 1);
    check("ferr_dv", ifc.dv, 0);
    check("ferr_q_kept", ifc.q, 32'h5A);
    rxq.push_back(8'hC3);
    drive_frame(8'hC3, 1'b1);
    repeat (3 * bitp) @(negedge clk);
    check("ferr_cleared", ifc.ferr, 0);
    loop_en = 1'b1;
    repeat (10) @(negedge clk);

    // Randomized words, divisors, modes, back-to-back THR refills
    for (int it = 0; it < 10; it++) begin
      div = int'($urandom_range(3, 20));
      m = 1'($urandom_range(0, 1));
      set_baud(m, div);
      w = $urandom;
      write_tx(w, 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        wait_txd_low();
        set_baud(1'($urandom_range(0, 1)), div);
        w = $urandom;
        write_tx(w, 1'b1);
      end
      wait_idle();
    end

    // Reset mid-burst
    set_baud(1'b1, 7);
    rx_mon_en = 1'b0;
    write_tx(32'h87654321, 1'b0);
    repeat (110) @(negedge clk);
    check("pre_rst_dv", ifc.dv, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_txd", ifc.txd, 1);
    check("rst_mid_busy", ifc.busy, 0);
    check("rst_mid_dv", ifc.dv, 0);
    check("rst_mid_q", ifc.q, 0);
    check("rst_mid_mode", ifc.mode, 0);
    txq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cur_mode = 1'b0;
    bitp = 8;
    rx_mon_en = 1'b1;
    write_tx(32'hA5A5A53C, 1'b0);
    wait_idle();

    check("txq_drained", txq.size(), 0);
    check("rxq_drained", rxq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
